// File: rtl/tff_pulse_reader_if.sv
// Handshake and cell-side signals of the TFF read controller.
// master = reader side, slave = cell/datapath side.
interface tff_pulse_reader_if #(
  parameter int WIDTH = 7
) ();
  logic             start;
  logic             busy;
  logic             re_out;
  logic             pulse_in;
  logic [WIDTH-1:0] data_out;
  logic             sat;
  logic             timeout;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  start, pulse_in, out_ready,
    output busy, re_out, data_out, sat, timeout, out_valid
  );

  modport slave (
    output start, pulse_in, out_ready,
    input  busy, re_out, data_out, sat, timeout, out_valid
  );
endinterface

// File: rtl/tff_pulse_reader.sv
// Read-side controller for a TFF cell: enables the read, times the
// returned Q pulse in clock cycles and hands the count out over valid/ready.
//
// state       | meaning
// S_IDLE      | waiting for start, cell read disabled
// S_WAIT_RISE | read enabled, waiting for the sampled pulse to go high
// S_MEASURE   | counting sampled-high cycles, saturating at MAX_COUNT
// S_DONE      | result held on data_out/sat/timeout until accepted
module tff_pulse_reader #(
  parameter int WIDTH     = 7,
  parameter int MAX_COUNT = 59,
  parameter int TIMEOUT   = 100
) (
  input  logic               clk,
  input  logic               rstb,
  tff_pulse_reader_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] C_MAX     = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] C_TC_LAST = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

  state_t           r_state;
  logic             r_p;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_tc;
  logic [WIDTH-1:0] r_data;
  logic             r_re_out;
  logic             r_sat;
  logic             r_timeout;
  logic             r_valid;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_p       <= 1'b0;
      r_cnt     <= '0;
      r_tc      <= '0;
      r_data    <= '0;
      r_re_out  <= 1'b0;
      r_sat     <= 1'b0;
      r_timeout <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      // every decision below looks at the registered sample, never the raw pin
      r_p <= bus.pulse_in;
      case (r_state)
        S_IDLE: begin
          r_tc <= '0;
          if (bus.start) begin
            r_state  <= S_WAIT_RISE;
            r_re_out <= 1'b1;
          end
        end
        S_WAIT_RISE: begin
          if (r_p) begin
            r_state <= S_MEASURE;
            r_cnt   <= C_ONE;
            r_tc    <= '0;
          end else if (r_tc == C_TC_LAST) begin
            r_state   <= S_DONE;
            r_re_out  <= 1'b0;
            r_valid   <= 1'b1;
            r_data    <= '0;
            r_sat     <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_tc <= r_tc + C_ONE;
          end
        end
        S_MEASURE: begin
          if (!r_p) begin
            r_state  <= S_DONE;
            r_re_out <= 1'b0;
            r_valid  <= 1'b1;
            r_data   <= r_cnt;
          end else if (r_cnt < C_MAX) begin
            r_cnt <= r_cnt + C_ONE;
          end else begin
            // clamped: count holds, tc guards against a cell stuck high
            r_sat <= 1'b1;
            if (r_tc == C_TC_LAST) begin
              r_state   <= S_DONE;
              r_re_out  <= 1'b0;
              r_valid   <= 1'b1;
              r_data    <= r_cnt;
              r_timeout <= 1'b1;
            end else begin
              r_tc <= r_tc + C_ONE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_sat     <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.re_out    = r_re_out;
  assign bus.data_out  = r_data;
  assign bus.sat       = r_sat;
  assign bus.timeout   = r_timeout;
  assign bus.out_valid = r_valid;

endmodule

// File: doc/tff_pulse_reader.md
Name: tff_pulse_reader

Overview:
- Read-side controller for the temporal flip-flop (TFF) storage cell.
- On request it drives the cell's read enable, times the returned Q pulse in clock cycles and converts the width to a binary count.
- Delivers the count over a valid/ready handshake to the digital datapath.
- Bridges race-logic temporal storage back into clocked binary logic.

Parameters:
- WIDTH, 7, bit width of the count, the internal counters and data_out.
- MAX_COUNT, 59, saturation value for the measured width. Matches the TFF cell capacity. Must be < 2^WIDTH.
- TIMEOUT, 100, maximum wait in cycles for the pulse to rise, and for it to fall once saturated. Must be < 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rstb  input  1  asynchronous active-low reset.
- start  input  1  read request; accepted only in IDLE.
- busy  output  1  high in every state except IDLE.
- re_out  output  1  read enable to the TFF cell (connects to the cell's RE).
- pulse_in  input  1  Q pulse returned by the TFF cell; synchronous to clk.
- data_out  output  WIDTH  measured pulse width in cycles.
- sat  output  1  width reached MAX_COUNT; data_out is clamped.
- timeout  output  1  pulse never rose, or never fell after saturation.
- out_valid  output  1  data_out, sat and timeout are valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset: asynchronous, rstb=0.
  - Clears state to IDLE, counters, and the pulse_in sample register p_r.
  - Drives re_out=0, busy=0, data_out=0, sat=0, timeout=0, out_valid=0.
  - A reset mid-read aborts with no result: re_out drops immediately and the FSM is in IDLE after release.
- pulse_in is registered once into p_r. All decisions use p_r, giving one cycle of input latency.
- IDLE:
  - start=1 → WAIT_RISE next cycle. re_out=1 and busy=1 from that cycle.
  - The timeout counter tc is cleared.
- WAIT_RISE:
  - re_out held at 1.
  - If p_r=1 → MEASURE with cnt=1.
  - Else tc increments. If tc reaches TIMEOUT-1 while p_r=0 → DONE with data_out=0, timeout=1, sat=0.
- MEASURE:
  - re_out held at 1.
  - p_r=1 and cnt<MAX_COUNT → cnt+1.
  - p_r=1 and cnt=MAX_COUNT → cnt holds, sat flag set, tc counts. When tc reaches TIMEOUT-1 → DONE with timeout=1, sat=1, data_out=MAX_COUNT.
  - p_r=0 → DONE with data_out=cnt and sat as set.
  - tc is cleared on entry to MEASURE.
- DONE:
  - re_out=0. out_valid=1, asserted in the first DONE cycle.
  - data_out, sat and timeout are stable while out_valid=1 and out_ready=0.
  - out_valid=1 and out_ready=1 in the same cycle → IDLE next cycle, out_valid=0.
  - data_out keeps its last value; sat and timeout clear on entry to IDLE.
  - out_ready high in any other state has no effect.
- Latency: a pulse of N cycles first seen high in p_r in cycle k gives out_valid in cycle k+N+1 (N ≤ MAX_COUNT).
- start while busy is ignored; there is no queuing.
- start asserted in the same cycle as a handshake completes is also ignored. The FSM is only in IDLE the following cycle.
- A pulse_in glitch of one high cycle measures 1.
- A re-rise after the fall is not seen: the FSM is already in DONE with re_out=0.
- Counter arithmetic is unsigned WIDTH-bit with explicit saturation. No wrap is permitted.
- busy = (state != IDLE).

Test Plan:
- Normal read: reset, start pulse; pulse_in high 25 cycles starting 3 cycles after re_out rises → data_out=25, sat=0, timeout=0. re_out falls in the out_valid cycle. One handshake returns to IDLE.
- Saturation: pulse_in high 80 cycles → data_out=59, sat=1, timeout=0. out_valid appears 1 cycle after the fall is sampled.
- Stuck high and no pulse:
  - pulse_in high indefinitely → after 59 counted cycles plus TIMEOUT=100 cycles: data_out=59, sat=1, timeout=1.
  - Separate run, pulse_in never rises → after 100 cycles: data_out=0, timeout=1.
- Backpressure and start filter:
  - Hold out_ready=0 for 10 cycles in DONE → out_valid and data_out stable. re_out stays 0. start pulses during this time are ignored.
  - out_ready=1 → out_valid drops next cycle.
- Reset mid-measure: rstb low after 12 counted cycles → re_out, busy and out_valid go 0 immediately. A new 7-cycle read after release returns data_out=7.
- Minimum width: single-cycle pulse_in → data_out=1. Back-to-back reads of 1, 59 and 30 cycles return exactly those values.
